smc_step_sequencer: RTL and testbench



---
 rtl/smc_step_sequencer_pkg.sv | 21 ++
 rtl/smc_step_sequencer_sincos.sv | 23 ++
 rtl/smc_step_sequencer.sv | 171 +++++++++++++++++
 tb/tb_smc_step_sequencer.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/smc_step_sequencer_pkg.sv
// Shared types and constants for the SMC micro-step sequencer.
// The read-back states only exist when SMC_SEQ_READBACK_EN is defined.
package smc_seq_pkg;

  localparam logic [6:0]  DUTY_BASE_DEFAULT = 7'h10;
  localparam logic [10:0] MAX_DUTY          = 11'd2047;

  // Quarter-wave sine, round(2047*sin(k*pi/32)) for k = 0..16
  localparam logic [10:0] SIN_TBL [0:16] = '{
    11'd0,    11'd201,  11'd399,  11'd594,  11'd783,  11'd965,
    11'd1137, 11'd1299, 11'd1447, 11'd1582, 11'd1702, 11'd1805,
    11'd1891, 11'd1959, 11'd2008, 11'd2037, MAX_DUTY
  };

`ifdef SMC_SEQ_READBACK_EN
  typedef enum logic [2:0] {IDLE, WR_A, RD_A, CK_A, WR_B, RD_B, CK_B} state_t;
`else
  typedef enum logic [1:0] {IDLE, WR_A, WR_B} state_t;
`endif

endpackage

// File: rtl/smc_step_sequencer_sincos.sv
// Combinational map from a 6-bit micro-step index to the signed-magnitude
// duty words for coil A (cosine) and coil B (sine).
module smc_sincos
  import smc_seq_pkg::*;
(
  input  logic [5:0]  idx,
  output logic [15:0] cos_word,
  output logic [15:0] sin_word
);

  // Odd quadrants walk the quarter table backwards; the upper half is negative
  function automatic logic [15:0] duty_of(input logic [5:0] i);
    logic [4:0]  k;
    logic [10:0] mag;
    k   = i[4] ? (5'd16 - {1'b0, i[3:0]}) : {1'b0, i[3:0]};
    mag = SIN_TBL[k];
    return {(i[5] && (mag != 11'd0)), 4'b0000, mag};
  endfunction

  assign sin_word = duty_of(idx);
  assign cos_word = duty_of(idx + 6'd16);

endmodule

// File: rtl/smc_step_sequencer.sv
// Step command sequencer: keeps a micro-step index per motor and writes the
// coil duty words to the SMC. Define SMC_SEQ_READBACK_EN for write read-back.
module smc_step_sequencer
  import smc_seq_pkg::*;
#(
  parameter int         NUM_MOTORS = 6,
  parameter logic [6:0] DUTY_BASE  = DUTY_BASE_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [2:0]  cmd_motor,
  input  logic        cmd_dir,
  input  logic        cmd_init,
  output logic        write,
  output logic        sel,
  output logic [6:0]  addr,
  output logic [15:0] datain,
  input  logic [15:0] dataout,
  output logic        bad_cmd,
  output logic        rb_err
);

  state_t      state;
  logic [5:0]  idx [NUM_MOTORS];
  logic [6:0]  addr_a;
  logic [15:0] sin_q;
  logic [5:0]  idx_cur;
  logic [5:0]  idx_new;
  logic [6:0]  chan_addr;
  logic [15:0] cos_w;
  logic [15:0] sin_w;
  logic        accept;
  logic        motor_ok;

  assign motor_ok  = ({29'd0, cmd_motor} < NUM_MOTORS);
  assign accept    = cmd_valid && cmd_ready;
  assign chan_addr = DUTY_BASE + {2'b00, cmd_motor, 2'b00};

  // Both duty words come from the index the command is about to store
  always_comb begin
    idx_cur = '0;
    if (motor_ok)
      idx_cur = idx[cmd_motor];
    if (cmd_init)
      idx_new = '0;
    else if (cmd_dir)
      idx_new = idx_cur + 6'd1;
    else
      idx_new = idx_cur - 6'd1;
  end

  smc_sincos u_sincos (
    .idx      (idx_new),
    .cos_word (cos_w),
    .sin_word (sin_w)
  );

`ifdef SMC_SEQ_READBACK_EN
  logic [15:0] cos_q;
`else
  logic unused_dataout;
  assign unused_dataout = ^dataout;
  assign rb_err         = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      cmd_ready <= 1'b1;
      write     <= 1'b0;
      sel       <= 1'b0;
      addr      <= '0;
      datain    <= '0;
      bad_cmd   <= 1'b0;
      addr_a    <= '0;
      sin_q     <= '0;
      for (int m = 0; m < NUM_MOTORS; m++)
        idx[m] <= '0;
`ifdef SMC_SEQ_READBACK_EN
      cos_q     <= '0;
      rb_err    <= 1'b0;
`endif
    end else begin
      bad_cmd <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            if (motor_ok) begin
              idx[cmd_motor] <= idx_new;
              state          <= WR_A;
              cmd_ready      <= 1'b0;
              sel            <= 1'b1;
              write          <= 1'b1;
              addr           <= chan_addr;
              datain         <= cos_w;
              addr_a         <= chan_addr;
              sin_q          <= sin_w;
`ifdef SMC_SEQ_READBACK_EN
              cos_q          <= cos_w;
`endif
            end else begin
              bad_cmd <= 1'b1;
            end
          end
        end
`ifdef SMC_SEQ_READBACK_EN
        WR_A: begin
          state  <= RD_A;
          write  <= 1'b0;
          datain <= '0;
        end
        RD_A: begin
          state <= CK_A;
          sel   <= 1'b0;
          addr  <= '0;
        end
        CK_A: begin
          if (dataout != cos_q)
            rb_err <= 1'b1;
          state  <= WR_B;
          sel    <= 1'b1;
          write  <= 1'b1;
          addr   <= addr_a + 7'd2;
          datain <= sin_q;
        end
        WR_B: begin
          state  <= RD_B;
          write  <= 1'b0;
          datain <= '0;
        end
        RD_B: begin
          state <= CK_B;
          sel   <= 1'b0;
          addr  <= '0;
        end
        CK_B: begin
          if (dataout != sin_q)
            rb_err <= 1'b1;
          state     <= IDLE;
          cmd_ready <= 1'b1;
        end
`else
        WR_A: begin
          state  <= WR_B;
          addr   <= addr_a + 7'd2;
          datain <= sin_q;
        end
        WR_B: begin
          state     <= IDLE;
          cmd_ready <= 1'b1;
          sel       <= 1'b0;
          write     <= 1'b0;
          addr      <= '0;
          datain    <= '0;
        end
`endif
        default: begin
          state     <= IDLE;
          cmd_ready <= 1'b1;
          sel       <= 1'b0;
          write     <= 1'b0;
          addr      <= '0;
          datain    <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_smc_step_sequencer.sv
// Bench for smc_step_sequencer: directed spec cases plus random step commands
// checked against a trigonometric model; honours SMC_SEQ_READBACK_EN.
module tb_smc_step_sequencer;

  localparam int  NUM_M = 6;
  localparam real PI    = 3.14159265358979;
`ifdef SMC_SEQ_READBACK_EN
  localparam int B_LAT = 4;
  localparam int READY_LAT = 7;
`else
  localparam int B_LAT = 2;
  localparam int READY_LAT = 3;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [2:0]  cmd_motor;
  logic        cmd_dir;
  logic        cmd_init;
  logic        write;
  logic        sel;
  logic [6:0]  addr;
  logic [15:0] datain;
  logic [15:0] dataout = 16'h0000;
  logic        bad_cmd;
  logic        rb_err;

  int          vectors = 0;
  int          miscompares = 0;
  int          idx_m [NUM_M];
  bit          rb_exp = 1'b0;
  bit          corrupt10 = 1'b0;
  logic [22:0] wr_log [$];
  int          sel_cnt = 0;
  logic [15:0] mem [0:127];

  smc_step_sequencer dut (
    .clk       (clk),
    .reset     (reset),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_motor (cmd_motor),
    .cmd_dir   (cmd_dir),
    .cmd_init  (cmd_init),
    .write     (write),
    .sel       (sel),
    .addr      (addr),
    .datain    (datain),
    .dataout   (dataout),
    .bad_cmd   (bad_cmd),
    .rb_err    (rb_err)
  );

  always #5 clk = ~clk;

  // SMC register file: captures writes, returns reads one cycle later
  initial for (int a = 0; a < 128; a++) mem[a] = 16'h0000;
  always @(posedge clk) begin
    if (sel && write)
      mem[addr] <= datain;
    if (sel && !write)
      dataout <= (corrupt10 && addr == 7'h10) ? 16'h0000 : mem[addr];
  end

  // Bus log sampled mid-cycle
  always @(negedge clk) begin
    if (sel === 1'b1 && write === 1'b1)
      wr_log.push_back({addr, datain});
    if (sel === 1'b1)
      sel_cnt++;
  end

  function automatic logic [15:0] model_duty(input real v);
    real a;
    int  mag;
    a   = (v < 0.0) ? -v : v;
    mag = $rtoi(a + 0.5);
    return {((v < 0.0) && (mag != 0)), 4'b0000, mag[10:0]};
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic doReset();
    reset     = 1'b1;
    cmd_valid = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    for (int m = 0; m < NUM_M; m++) idx_m[m] = 0;
    rb_exp = 1'b0;
  endtask

  // Presents one command, waits for the handshake and checks the bus cycles.
  // With hold set, the next command is left on the bus while this one runs.
  task automatic applyStimulus(input int m, input bit dir, input bit init,
                               input bit hold, input int nm, input bit ndir, input bit ninit);
    bit          got;
    int          waited;
    int          n0;
    real         ang;
    logic [15:0] ce;
    logic [15:0] se;
    logic [6:0]  ca;
    cmd_valid = 1'b1;
    cmd_motor = 3'(m);
    cmd_dir   = dir;
    cmd_init  = init;
    got    = 1'b0;
    waited = 0;
    while (!got && waited < 50) begin
      if (cmd_ready === 1'b1) begin
        @(posedge clk);
        got = 1'b1;
      end else begin
        @(negedge clk);
        waited++;
      end
    end
    if (!got) begin
      checkOutput("handshake_timeout", 32'd0, 32'd1);
      cmd_valid = 1'b0;
      return;
    end
    n0 = wr_log.size();
    @(negedge clk);
    if (m >= NUM_M) begin
      checkOutput("bad.pulse", bad_cmd, 1);
      checkOutput("bad.sel", sel, 0);
      checkOutput("bad.ready", cmd_ready, 1);
      cmd_valid = 1'b0;
      @(negedge clk);
      checkOutput("bad.clear", bad_cmd, 0);
      checkOutput("bad.nowrite", wr_log.size(), n0);
      return;
    end
    if (init)     idx_m[m] = 0;
    else if (dir) idx_m[m] = (idx_m[m] + 1) % 64;
    else          idx_m[m] = (idx_m[m] + 63) % 64;
    ang = real'(idx_m[m]) * PI / 32.0;
    ce  = model_duty(2047.0 * $cos(ang));
    se  = model_duty(2047.0 * $sin(ang));
    ca  = 7'(7'h10 + 2 * (2 * m));
    if (corrupt10 && ca == 7'h10 && ce != 16'h0000 && B_LAT > 2) rb_exp = 1'b1;
    for (int k = 1; k <= READY_LAT; k++) begin
      if (k > 1) @(negedge clk);
      if (k == 1) begin
        checkOutput("A.selwr", {sel, write}, 2'b11);
        checkOutput("A.addr", addr, ca);
        checkOutput("A.data", datain, ce);
        checkOutput("A.busy", cmd_ready, 0);
        if (hold) begin
          cmd_motor = 3'(nm);
          cmd_dir   = ndir;
          cmd_init  = ninit;
        end else begin
          cmd_valid = 1'b0;
        end
      end
`ifdef SMC_SEQ_READBACK_EN
      if (k == 2 || k == 5) begin
        checkOutput("RD.selwr", {sel, write}, 2'b10);
        checkOutput("RD.addr", addr, (k == 2) ? ca : ca + 7'd2);
      end
      if (k == 3 || k == 6)
        checkOutput("CK.sel", sel, 0);
`endif
      if (k == B_LAT) begin
        checkOutput("B.selwr", {sel, write}, 2'b11);
        checkOutput("B.addr", addr, ca + 7'd2);
        checkOutput("B.data", datain, se);
      end
      if (k == READY_LAT - 1)
        checkOutput("busy.ready", cmd_ready, 0);
      if (k == READY_LAT) begin
        checkOutput("done.ready", cmd_ready, 1);
        checkOutput("done.selwr", {sel, write}, 2'b00);
        checkOutput("done.rb_err", rb_err, rb_exp);
      end
    end
  endtask

  initial begin
    int n0;
    int s0;
    int cm [60];
    bit cd [60];
    bit ci [60];
    cmd_valid = 1'b0;
    cmd_motor = 3'd0;
    cmd_dir   = 1'b0;
    cmd_init  = 1'b0;
    doReset();

    $display("[TB] reset and idle");
    checkOutput("rst.ready", cmd_ready, 1);
    checkOutput("rst.bus", {sel, write, addr, datain}, 0);
    checkOutput("rst.flags", {bad_cmd, rb_err}, 2'b00);
    n0 = wr_log.size();
    s0 = sel_cnt;
    repeat (20) @(negedge clk);
    checkOutput("idle.nowrite", wr_log.size(), n0);
    checkOutput("idle.nosel", sel_cnt, s0);
    checkOutput("idle.ready", cmd_ready, 1);

    $display("[TB] forward step");
    applyStimulus(0, 1'b1, 1'b0, 1'b0, 0, 1'b0, 1'b0);
    checkOutput("fwd.logA", wr_log[wr_log.size() - 2], {7'h10, 16'h07F5});
    checkOutput("fwd.logB", wr_log[wr_log.size() - 1], {7'h12, 16'h00C9});

    $display("[TB] reverse wrap");
    doReset();
    applyStimulus(0, 1'b0, 1'b0, 1'b0, 0, 1'b0, 1'b0);
    checkOutput("rev.logA", wr_log[wr_log.size() - 2], {7'h10, 16'h07F5});
    checkOutput("rev.logB", wr_log[wr_log.size() - 1], {7'h12, 16'h80C9});

    $display("[TB] motor 5 steps then init");
    for (int i = 0; i < 10; i++)
      applyStimulus(5, 1'b1, 1'b0, (i < 9), 5, 1'b1, 1'b0);
    applyStimulus(5, 1'b0, 1'b1, 1'b0, 0, 1'b0, 1'b0);
    checkOutput("init.logA", wr_log[wr_log.size() - 2], {7'h24, 16'h07FF});
    checkOutput("init.logB", wr_log[wr_log.size() - 1], {7'h26, 16'h0000});

    $display("[TB] invalid motor");
    applyStimulus(6, 1'b1, 1'b0, 1'b0, 0, 1'b0, 1'b0);
    checkOutput("bad.idle_ready", cmd_ready, 1);

    $display("[TB] reset mid-sequence");
    n0 = wr_log.size();
    cmd_valid = 1'b1;
    cmd_motor = 3'd2;
    cmd_dir   = 1'b1;
    cmd_init  = 1'b0;
    checkOutput("mid.ready", cmd_ready, 1);
    @(posedge clk);
    @(negedge clk);
    checkOutput("mid.A", {sel, write}, 2'b11);
    cmd_valid = 1'b0;
    reset     = 1'b1;
    @(negedge clk);
    checkOutput("mid.abort", {sel, write, cmd_ready, rb_err}, 4'b0010);
    reset = 1'b0;
    repeat (5) @(negedge clk);
    checkOutput("mid.noB", wr_log.size(), n0 + 1);
    for (int m = 0; m < NUM_M; m++) idx_m[m] = 0;
    rb_exp = 1'b0;
    applyStimulus(2, 1'b1, 1'b0, 1'b0, 0, 1'b0, 1'b0);
    checkOutput("mid.logA", wr_log[wr_log.size() - 2], {7'h18, 16'h07F5});
    checkOutput("mid.logB", wr_log[wr_log.size() - 1], {7'h1A, 16'h00C9});

`ifdef SMC_SEQ_READBACK_EN
    $display("[TB] read-back error");
    doReset();
    corrupt10 = 1'b1;
    applyStimulus(0, 1'b1, 1'b0, 1'b0, 0, 1'b0, 1'b0);
    corrupt10 = 1'b0;
    applyStimulus(1, 1'b1, 1'b0, 1'b0, 0, 1'b0, 1'b0);
    checkOutput("rb.sticky", rb_err, 1);
    doReset();
    checkOutput("rb.cleared", rb_err, 0);
`endif

    $display("[TB] random commands");
    for (int i = 0; i < 60; i++) begin
      int r;
      r     = $urandom_range(0, 15);
      cm[i] = (r < 14) ? (r % 6) : (6 + r - 14);
      cd[i] = 1'($urandom_range(0, 1));
      ci[i] = ($urandom_range(0, 9) == 0);
    end
    for (int i = 0; i < 60; i++) begin
      bit h;
      h = (i < 59) && (cm[i] < NUM_M) && ($urandom_range(0, 1) == 1);
      applyStimulus(cm[i], cd[i], ci[i], h,
                    (i < 59) ? cm[i + 1] : 0,
                    (i < 59) ? cd[i + 1] : 1'b0,
                    (i < 59) ? ci[i + 1] : 1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
